keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the rows of the 4x4 matrix keypad one at a time and samples its columns.
- Debounces each press and release.
- Emits the 4-bit key code consumed by the seven-segment decoder.
- Sits between the keypad pins and the display/decoder path; it is the encoding end of the key-code interface.

Parameters:
- SCAN_DIV, 27000, clock cycles per row dwell; one column sample ("tick") per dwell.
- DEBOUNCE_CNT, 10, consecutive equal tick samples needed to accept a press or a release; must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- col_i  in  4  keypad columns, active-low, pulled up, asynchronous to clk
- row_o  out  4  keypad row drive, active-low, exactly one bit low
- key_code  out  4  {row_idx[1:0], col_idx[1:0]}; holds the last accepted key
- key_valid  out  1  one-cycle pulse when a debounced press is accepted
- key_held  out  1  high while the accepted key is still pressed, including release debounce

Behaviour:
- Single clock domain. Reset is synchronous and active-high and uses the clk and rst ports.
- Reset values:
  - row_o=4'b1110, key_code=4'h0, key_valid=0, key_held=0.
  - State SCAN, row_idx=0.
  - Tick counter, debounce counter and synchronizer flops are all cleared; synchronizer flops reset to 4'b1111.
- col_i passes through a 2-flop synchronizer (col_s) before any use.
- Tick counter counts 0..SCAN_DIV-1 and wraps. tick=1 in the cycle the count equals SCAN_DIV-1. The counter runs in all states.
- row_o = ~(4'b0001 << row_idx), registered.
- Column priority: when several col_s bits are low, the lowest index wins.
- Code mapping: 0=A, 1=3, 2=2, 3=1, 4=B, 5=6, 6=5, 7=4, 8=C, 9=9, A=8, B=7, C=D, D=#, E=0, F=*.
- FSM transitions (all evaluated only on tick):
  - SCAN, col_s==4'hF: row_idx++ (3 wraps to 0).
  - SCAN, any col_s low: capture col_idx using the priority rule, db_cnt=1, go to DEBOUNCE. row_idx is frozen.
  - DEBOUNCE, col_s[col_idx]==0: db_cnt++. When db_cnt reaches DEBOUNCE_CNT, go to PRESSED. In the next cycle, key_code={row_idx,col_idx}, key_valid=1 for exactly one cycle, and key_held=1.
  - DEBOUNCE, col_s[col_idx]==1: treat as bounce. Go to SCAN, row_idx++, and do not pulse.
  - PRESSED, col_s[col_idx]==1: db_cnt=1, go to RELEASE.
  - RELEASE, col_s[col_idx]==1: db_cnt++. When db_cnt reaches DEBOUNCE_CNT, go to SCAN, key_held=0, row_idx++.
  - RELEASE, col_s[col_idx]==0: return to PRESSED with no new pulse.
- Other keys are ignored from DEBOUNCE through RELEASE. This covers other columns in the same row and any key in another row.
- Press latency: key_valid rises in the cycle after the tick that takes the DEBOUNCE_CNT-th consecutive low sample, plus the 2-cycle synchronizer delay.
- key_code is not cleared on release. It changes only when key_valid pulses.
- rst asserted mid-operation: on the next edge every output and all state return to reset values. A key still held after reset is rediscovered through SCAN and produces a fresh pulse.

Decomposition:
- keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}
  - key-code localparams KEY_A..KEY_STAR, using the mapping above
  - ROWS=4, COLS=4
- One sub-module, keypad_col_sync: 4-bit 2-flop synchronizer with synchronous reset to 4'b1111.
- Tick counter and FSM stay in keypad_scanner.

Test Plan:
The bench uses a keypad model that drives col_i from row_o and the pressed-key set, with SCAN_DIV=4 and DEBOUNCE_CNT=3.
- Reset: rst=1 for 2 cycles -> row_o=1110, key_code=0, key_valid=0, key_held=0.
- Idle: no keys pressed -> row_o steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_valid never asserts.
- Clean press of row1/col2 ('5') -> exactly one key_valid pulse with key_code=4'h6 and key_held=1; row_o stays 1101 while held.
- Bounce: row2/col0 low for 1 tick, then high -> no key_valid pulse, key_held stays 0, scanning resumes at row3.
- Release bounce: while '5' is held, alternate high/low on 2 ticks, then high for 3 ticks -> no second pulse; key_held falls after the 3rd high tick; key_code stays 4'h6.
- Multiple keys and reset:
  - Row0 col0 and col3 pressed together -> key_code=4'h0 (A).
  - Assert rst while held -> all outputs return to reset values; after release of rst, a fresh pulse with key_code=4'h0 is produced.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key-code constants and column priority helper for the keypad scanner
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Key codes are {row_idx, col_idx}; names give the legend printed on the key
    localparam logic [3:0] KEY_A    = 4'h0;
    localparam logic [3:0] KEY_3    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_1    = 4'h3;
    localparam logic [3:0] KEY_B    = 4'h4;
    localparam logic [3:0] KEY_6    = 4'h5;
    localparam logic [3:0] KEY_5    = 4'h6;
    localparam logic [3:0] KEY_4    = 4'h7;
    localparam logic [3:0] KEY_C    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_8    = 4'hA;
    localparam logic [3:0] KEY_7    = 4'hB;
    localparam logic [3:0] KEY_D    = 4'hC;
    localparam logic [3:0] KEY_HASH = 4'hD;
    localparam logic [3:0] KEY_0    = 4'hE;
    localparam logic [3:0] KEY_STAR = 4'hF;

    // Index of the lowest active-low column; lowest index wins when several are low
    function automatic logic [1:0] first_low(input logic [COLS-1:0] col);
        first_low = 2'd0;
        for (int i = COLS - 1; i >= 0; i--)
            if (!col[i]) first_low = 2'(i);
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: two-flop synchronizer for the asynchronous keypad columns, idle value all ones
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_raw,
    output logic [COLS-1:0] col_s
);

    logic [COLS-1:0] meta;

    // Two-stage capture; reset to "no column pulled low"
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= '1;
            col_s <= '1;
        end else begin
            meta  <= col_raw;
            col_s <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scans a 4x4 keypad, debounces press/release and emits the pressed key code
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 27000,
    parameter int DEBOUNCE_CNT = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_i,
    output logic [ROWS-1:0] row_o,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    logic [COLS-1:0] col_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    state_t          state, state_n;
    logic [1:0]      row_idx, row_n;
    logic [1:0]      col_idx, col_n;
    logic [DW-1:0]   db_cnt, db_n;
    logic            valid_q, valid_n;
    logic [3:0]      code_q, code_n;
    logic [ROWS-1:0] row_q;
    logic            hit;
    logic            last;

    keypad_col_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .col_raw (col_i),
        .col_s   (col_s)
    );

    assign tick = tick_cnt == TW'(SCAN_DIV - 1);
    assign hit  = ~col_s[col_idx];
    assign last = db_cnt == DW'(DEBOUNCE_CNT - 1);

    // Free-running dwell counter; one sample tick per row dwell in every state
    always_ff @(posedge clk) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    // State register together with the scan/debounce datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCAN;
            row_idx <= '0;
            col_idx <= '0;
            db_cnt  <= '0;
            valid_q <= 1'b0;
            code_q  <= KEY_A;
            row_q   <= 4'b1110;
        end else begin
            state   <= state_n;
            row_idx <= row_n;
            col_idx <= col_n;
            db_cnt  <= db_n;
            valid_q <= valid_n;
            code_q  <= code_n;
            row_q   <= ~(4'b0001 << row_idx);
        end
    end

    // Next state: everything advances only on tick, other keys ignored once a column is captured
    always_comb begin
        state_n = state;
        row_n   = row_idx;
        col_n   = col_idx;
        db_n    = db_cnt;
        valid_n = 1'b0;
        code_n  = code_q;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (col_s != '1) begin
                        col_n   = first_low(col_s);
                        db_n    = DW'(1);
                        state_n = DEBOUNCE;
                    end else begin
                        row_n = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!hit) begin
                        state_n = SCAN;
                        row_n   = row_idx + 2'd1;
                    end else if (last) begin
                        state_n = PRESSED;
                        valid_n = 1'b1;
                        code_n  = {row_idx, col_idx};
                    end else begin
                        db_n = db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!hit) begin
                        db_n    = DW'(1);
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (hit) begin
                        state_n = PRESSED;
                    end else if (last) begin
                        state_n = SCAN;
                        row_n   = row_idx + 2'd1;
                    end else begin
                        db_n = db_cnt + 1'b1;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    // Outputs: held covers both the steady press and the release debounce window
    always_comb begin
        row_o     = row_q;
        key_code  = code_q;
        key_valid = valid_q;
        key_held  = (state == PRESSED) || (state == RELEASE);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model plus scoreboard of expected key codes for keypad_scanner
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_i;
    logic [3:0]  row_o;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;
    int          ec = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pushed = 0;
    int          rd = 0;
    logic [3:0]  obs[$];
    logic [3:0]  exp_q[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_i     (col_i),
        .row_o     (row_o),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its column low while its row is driven low
    always_comb begin
        col_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_o[r] && keys[r*4+c]) col_i[c] = 1'b0;
    end

    // Cycle count since reset; DUT tick edge leaves ec a multiple of 4
    always @(posedge clk) ec <= rst ? 0 : ec + 1;

    // Record every cycle key_valid is high together with the code shown
    always @(negedge clk) if (key_valid) obs.push_back(key_code);

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic next_tick();
        cyc(1);
        while (ec % 4 != 0) cyc(1);
    endtask

    task automatic expect_key(input logic [3:0] code);
        exp_q.push_back(code);
        n_pushed++;
    endtask

    task automatic score(input string tag);
        chk({tag, "_count"}, 16'(obs.size()), 16'(n_pushed));
        while (rd < obs.size() && exp_q.size() > 0) begin
            chk({tag, "_code"}, 16'(obs[rd]), 16'(exp_q.pop_front()));
            rd++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row", 16'(row_o), 16'b1110);
        chk("rst_code", 16'(key_code), 16'h0);
        chk("rst_valid", 16'(key_valid), 16'h0);
        chk("rst_held", 16'(key_held), 16'h0);
        @(negedge clk) rst = 1'b0;

        cyc(1);
        chk("idle_row0", 16'(row_o), 16'b1110);
        cyc(4);
        chk("idle_row1", 16'(row_o), 16'b1101);
        cyc(4);
        chk("idle_row2", 16'(row_o), 16'b1011);
        cyc(4);
        chk("idle_row3", 16'(row_o), 16'b0111);
        cyc(4);
        chk("idle_wrap", 16'(row_o), 16'b1110);
        score("idle");

        keys[4*1+2] = 1'b1;
        expect_key(KEY_5);
        cyc(30);
        score("press5");
        chk("press5_held", 16'(key_held), 16'h1);
        chk("press5_row", 16'(row_o), 16'b1101);
        chk("press5_valid_low", 16'(key_valid), 16'h0);

        next_tick();
        keys[4*1+2] = 1'b0;
        next_tick();
        keys[4*1+2] = 1'b1;
        next_tick();
        chk("rel_bounce_held", 16'(key_held), 16'h1);
        keys[4*1+2] = 1'b0;
        next_tick();
        next_tick();
        chk("rel_held_2nd_high", 16'(key_held), 16'h1);
        next_tick();
        chk("rel_held_drop", 16'(key_held), 16'h0);
        chk("rel_code_kept", 16'(key_code), 16'(KEY_5));
        score("release");

        keys[4*2+0] = 1'b1;
        next_tick();
        chk("bounce_held_db", 16'(key_held), 16'h0);
        keys[4*2+0] = 1'b0;
        next_tick();
        chk("bounce_held", 16'(key_held), 16'h0);
        cyc(1);
        chk("bounce_row3", 16'(row_o), 16'b0111);
        score("bounce");

        keys[4*0+0] = 1'b1;
        keys[4*0+3] = 1'b1;
        expect_key(KEY_A);
        cyc(60);
        score("multi");
        chk("multi_held", 16'(key_held), 16'h1);
        chk("multi_row", 16'(row_o), 16'b1110);

        @(negedge clk) rst = 1'b1;
        cyc(1);
        chk("midrst_row", 16'(row_o), 16'b1110);
        chk("midrst_code", 16'(key_code), 16'h0);
        chk("midrst_valid", 16'(key_valid), 16'h0);
        chk("midrst_held", 16'(key_held), 16'h0);
        @(negedge clk) rst = 1'b0;
        expect_key(KEY_A);
        cyc(30);
        score("after_rst");
        chk("after_rst_held", 16'(key_held), 16'h1);
        chk("after_rst_code", 16'(key_code), 16'(KEY_A));

        keys = '0;
        cyc(40);
        chk("final_held", 16'(key_held), 16'h0);
        score("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
